multi_counter_bank: RTL

Parametrised bank of N_CH independent modulo counters, each advanced by its own raw push-button. Buttons are synchronised and debounced inside the block. A run-time input selects how many channels are live. Any counter wrapping from MODULO-1 to 0 fires a timed square-wave beep on a single buzzer output. Sits between the board button/switch inputs and the display/buzzer logic, replacing per-count fixed instantiations with one run-time-configurable block.

---
 rtl/multi_counter_bank.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/multi_counter_bank.sv
// Bank of N_CH debounced push-button modulo counters with a wrap-triggered buzzer.
// Define BEEP_QUEUE_EN to queue wrap beeps (pending counter + silent gaps) instead of retriggering.
module multi_counter_bank #(
    parameter int N_CH        = 10,
    parameter int CW          = 4,
    parameter int MODULO      = 10,
    parameter int DEB_CYCLES  = 1000000,
    parameter int BEEP_CYCLES = 25000000,
    parameter int TONE_DIV    = 50000
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic [4:0]           active_cnt,
    input  logic [N_CH-1:0]      btn,
    output logic [N_CH*CW-1:0]   values,
    output logic [N_CH-1:0]      wrap_flags,
    output logic                 buzzer,
    output logic                 beeping
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int BW = $clog2(BEEP_CYCLES + 1);
    localparam int TW = $clog2(TONE_DIV + 1);

    logic [N_CH-1:0] sync1, sync2, deb, deb_q, press, live;
    logic [DW-1:0]   deb_cnt [N_CH];
    logic [CW-1:0]   cnt     [N_CH];
    logic [4:0]      live_n;

    logic [BW-1:0]   beep_tmr;
    logic [TW-1:0]   tone_div;
    logic            buzz;

    always_comb begin
        if (active_cnt == 5'd0)
            live_n = 5'd1;
        else if (active_cnt > 5'(N_CH))
            live_n = 5'(N_CH);
        else
            live_n = active_cnt;
        live = '0;
        for (int unsigned i = 0; i < N_CH; i++)
            live[i] = (5'(i) < live_n);
    end

    always_comb begin
        values = '0;
        for (int unsigned i = 0; i < N_CH; i++)
            values[i*CW +: CW] = cnt[i];
    end

    // Level is accepted only after DEB_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            press <= '0;
            for (int unsigned i = 0; i < N_CH; i++)
                deb_cnt[i] <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            deb_q <= deb;
            press <= deb & ~deb_q;
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrap_flags <= '0;
            for (int unsigned i = 0; i < N_CH; i++)
                cnt[i] <= '0;
        end else begin
            wrap_flags <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (!live[i]) begin
                    cnt[i] <= '0;
                end else if (press[i] && enable) begin
                    if (cnt[i] == CW'(MODULO - 1)) begin
                        cnt[i]        <= '0;
                        wrap_flags[i] <= 1'b1;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

`ifdef BEEP_QUEUE_EN
    localparam int GAP_CYCLES = BEEP_CYCLES / 4;

    typedef enum logic [1:0] {IDLE, TONE, GAP} beep_state_t;
    beep_state_t state;
    logic [3:0]  pending;
    logic [5:0]  pend_sum, pend_next;
    logic        take;

    // New wraps are counted in the same cycle a beep may be launched from them.
    always_comb begin
        pend_sum = 6'(pending) + 6'($countones(wrap_flags));
        take     = 1'b0;
        case (state)
            IDLE:    take = (pend_sum != 6'd0);
            TONE:    take = (GAP_CYCLES == 0) && (beep_tmr == BW'(1)) && (pend_sum != 6'd0);
            GAP:     take = (beep_tmr == BW'(1)) && (pend_sum != 6'd0);
            default: take = 1'b0;
        endcase
        pend_next = pend_sum - 6'(take);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            pending  <= '0;
            beep_tmr <= '0;
            tone_div <= '0;
            buzz     <= 1'b0;
        end else begin
            pending <= (pend_next > 6'd15) ? 4'd15 : pend_next[3:0];
            if (take) begin
                state    <= TONE;
                beep_tmr <= BW'(BEEP_CYCLES);
                tone_div <= '0;
                buzz     <= 1'b0;
            end else begin
                case (state)
                    TONE: begin
                        if (beep_tmr == BW'(1)) begin
                            buzz     <= 1'b0;
                            tone_div <= '0;
                            if (GAP_CYCLES != 0) begin
                                state    <= GAP;
                                beep_tmr <= BW'(GAP_CYCLES);
                            end else begin
                                state    <= IDLE;
                                beep_tmr <= '0;
                            end
                        end else begin
                            beep_tmr <= beep_tmr - 1'b1;
                            if (tone_div == TW'(TONE_DIV - 1)) begin
                                tone_div <= '0;
                                buzz     <= ~buzz;
                            end else begin
                                tone_div <= tone_div + 1'b1;
                            end
                        end
                    end
                    GAP: begin
                        beep_tmr <= beep_tmr - 1'b1;
                        if (beep_tmr == BW'(1))
                            state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign beeping = (state == TONE);
    assign buzzer  = buzz;
`else
    // Retrigger reloads the timer but keeps the buzzer level, so the tone phase carries on.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beep_tmr <= '0;
            tone_div <= '0;
            buzz     <= 1'b0;
        end else if (|wrap_flags) begin
            beep_tmr <= BW'(BEEP_CYCLES);
            tone_div <= '0;
        end else if (beep_tmr != '0) begin
            beep_tmr <= beep_tmr - 1'b1;
            if (beep_tmr == BW'(1)) begin
                tone_div <= '0;
                buzz     <= 1'b0;
            end else if (tone_div == TW'(TONE_DIV - 1)) begin
                tone_div <= '0;
                buzz     <= ~buzz;
            end else begin
                tone_div <= tone_div + 1'b1;
            end
        end else begin
            tone_div <= '0;
            buzz     <= 1'b0;
        end
    end

    assign beeping = (beep_tmr != '0);
    assign buzzer  = buzz;
`endif

endmodule
